// File: rtl/mc_port_sched.sv
// mc_port_sched: steps a 1-based port selector across the enabled measurement
// ports. It dwells on each port for a programmable number of catch events, and
// supports continuous or single-sweep operation with a synchronous stop.
// Optional build macro: MC_PORT_SCHED_ONEHOT_EN adds the o_onehot decode of ctrl.
module mc_port_sched #(
    parameter int MAX_PORTS = 32,
    parameter int PORT_W    = 6,
    parameter int RPT_W     = 16
) (
    input  logic                 io_clk,
    input  logic                 io_rst,
    input  logic                 io_catch,
    input  logic                 io_stop,
    input  logic [RPT_W-1:0]     io_RptNo,
    input  logic [PORT_W-1:0]    portNo,
    input  logic [MAX_PORTS-1:0] io_portMask,
    input  logic                 io_mode,
    output logic [PORT_W-1:0]    ctrl,
    output logic [RPT_W-1:0]     o_rptCnt,
    output logic                 o_busy,
    output logic                 o_sweep,
    output logic                 o_err
`ifdef MC_PORT_SCHED_ONEHOT_EN
    ,
    output logic [MAX_PORTS-1:0] o_onehot
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Ports 1..min(pn, MAX_PORTS) whose mask bit is set
    function automatic logic [MAX_PORTS-1:0] elig_of(input logic [PORT_W-1:0] pn,
                                                     input logic [MAX_PORTS-1:0] mask);
        logic [MAX_PORTS-1:0] v;
        int lim;
        lim = int'(pn);
        if (lim > MAX_PORTS) lim = MAX_PORTS;
        for (int i = 0; i < MAX_PORTS; i++) v[i] = mask[i] && (i < lim);
        return v;
    endfunction

    // Lowest eligible port number, 0 when none
    function automatic logic [PORT_W-1:0] first_of(input logic [MAX_PORTS-1:0] v);
        logic [PORT_W-1:0] r;
        r = '0;
        for (int i = MAX_PORTS - 1; i >= 0; i--) if (v[i]) r = PORT_W'(i + 1);
        return r;
    endfunction

    // Lowest eligible port strictly above cur, 0 when none (caller handles wrap)
    function automatic logic [PORT_W-1:0] next_of(input logic [MAX_PORTS-1:0] v,
                                                  input logic [PORT_W-1:0] cur);
        logic [PORT_W-1:0] r;
        r = '0;
        for (int i = MAX_PORTS - 1; i >= 0; i--)
            if (v[i] && (i + 1 > int'(cur))) r = PORT_W'(i + 1);
        return r;
    endfunction

`ifdef MC_PORT_SCHED_ONEHOT_EN
    function automatic logic [MAX_PORTS-1:0] onehot_of(input logic [PORT_W-1:0] c);
        logic [MAX_PORTS-1:0] r;
        for (int i = 0; i < MAX_PORTS; i++) r[i] = (int'(c) == i + 1);
        return r;
    endfunction
`endif

    logic [0:0]           state_q, state_d;
    // Shadow config: portNo and mask are folded into one eligibility vector at start
    logic [MAX_PORTS-1:0] sh_elig_q, sh_elig_d;
    logic [RPT_W-1:0]     sh_rpt_q, sh_rpt_d;
    logic                 sh_mode_q, sh_mode_d;
    logic [PORT_W-1:0]    ctrl_d;
    logic [RPT_W-1:0]     cnt_d;
    logic                 busy_d, sweep_d, err_d;

    logic [MAX_PORTS-1:0] live_elig;
    logic [PORT_W-1:0]    live_first, run_first, run_next;

    assign live_elig  = elig_of(portNo, io_portMask);
    assign live_first = first_of(live_elig);
    assign run_first  = first_of(sh_elig_q);
    assign run_next   = next_of(sh_elig_q, ctrl);

    // Next-state decision: stop beats catch; every catch is resolved in one cycle
    always_comb begin
        state_d   = state_q;
        sh_elig_d = sh_elig_q;
        sh_rpt_d  = sh_rpt_q;
        sh_mode_d = sh_mode_q;
        ctrl_d    = ctrl;
        cnt_d     = o_rptCnt;
        busy_d    = o_busy;
        sweep_d   = 1'b0;
        err_d     = 1'b0;
        if (io_stop) begin
            state_d = ST_IDLE;
            ctrl_d  = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (io_catch) begin
                sh_elig_d = live_elig;
                sh_rpt_d  = (io_RptNo == '0) ? RPT_W'(1) : io_RptNo;
                sh_mode_d = io_mode;
                if (live_first != '0) begin
                    state_d = ST_RUN;
                    ctrl_d  = live_first;
                    cnt_d   = RPT_W'(1);
                    busy_d  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (io_catch) begin
            if (o_rptCnt < sh_rpt_q) begin
                cnt_d = o_rptCnt + 1'b1;
            end else if (run_next != '0) begin
                ctrl_d = run_next;
                cnt_d  = RPT_W'(1);
            end else begin
                sweep_d = 1'b1;
                if (!sh_mode_q) begin
                    ctrl_d = run_first;
                    cnt_d  = RPT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    ctrl_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
        end
    end

    // Register state, shadows and all outputs; async reset clears everything
    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            state_q   <= ST_IDLE;
            sh_elig_q <= '0;
            sh_rpt_q  <= '0;
            sh_mode_q <= 1'b0;
            ctrl      <= '0;
            o_rptCnt  <= '0;
            o_busy    <= 1'b0;
            o_sweep   <= 1'b0;
            o_err     <= 1'b0;
`ifdef MC_PORT_SCHED_ONEHOT_EN
            o_onehot  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sh_elig_q <= sh_elig_d;
            sh_rpt_q  <= sh_rpt_d;
            sh_mode_q <= sh_mode_d;
            ctrl      <= ctrl_d;
            o_rptCnt  <= cnt_d;
            o_busy    <= busy_d;
            o_sweep   <= sweep_d;
            o_err     <= err_d;
`ifdef MC_PORT_SCHED_ONEHOT_EN
            o_onehot  <= onehot_of(ctrl_d);
`endif
        end
    end

endmodule

// File: tb/tb_mc_port_sched.sv
// Self-checking bench for mc_port_sched: directed scenarios plus randomized
// traffic, compared against a list-based behavioural model.
module tb_mc_port_sched;
    localparam int MAX_PORTS = 32;
    localparam int PORT_W    = 6;
    localparam int RPT_W     = 16;
    localparam int VW        = PORT_W + RPT_W + 3;

    logic                 io_clk = 1'b0;
    logic                 io_rst = 1'b1;
    logic                 io_catch = 1'b0;
    logic                 io_stop = 1'b0;
    logic [RPT_W-1:0]     io_RptNo = '0;
    logic [PORT_W-1:0]    portNo = '0;
    logic [MAX_PORTS-1:0] io_portMask = '0;
    logic                 io_mode = 1'b0;
    logic [PORT_W-1:0]    ctrl;
    logic [RPT_W-1:0]     o_rptCnt;
    logic                 o_busy, o_sweep, o_err;
`ifdef MC_PORT_SCHED_ONEHOT_EN
    logic [MAX_PORTS-1:0] o_onehot;
`endif

    mc_port_sched #(.MAX_PORTS(MAX_PORTS), .PORT_W(PORT_W), .RPT_W(RPT_W)) dut (
        .io_clk(io_clk), .io_rst(io_rst), .io_catch(io_catch), .io_stop(io_stop),
        .io_RptNo(io_RptNo), .portNo(portNo), .io_portMask(io_portMask), .io_mode(io_mode),
        .ctrl(ctrl), .o_rptCnt(o_rptCnt), .o_busy(o_busy), .o_sweep(o_sweep), .o_err(o_err)
`ifdef MC_PORT_SCHED_ONEHOT_EN
        , .o_onehot(o_onehot)
`endif
    );

    always #5 io_clk = ~io_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: the sweep is a list of eligible ports walked by index
    int m_ports[$];
    int m_idx, m_cnt, m_rpt;
    bit m_run, m_mode, m_sweep, m_err;

    wire [VW-1:0] obs = {ctrl, o_rptCnt, o_busy, o_sweep, o_err};

    function automatic int m_ctrl();
        return m_run ? m_ports[m_idx] : 0;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {PORT_W'(m_ctrl()), RPT_W'(m_cnt), m_run, m_sweep, m_err};
    endfunction

    function automatic logic [MAX_PORTS-1:0] exp_onehot();
        logic [MAX_PORTS-1:0] one;
        one = 1;
        return (m_ctrl() == 0) ? '0 : (one << (m_ctrl() - 1));
    endfunction

    task automatic model_reset();
        m_run = 0; m_cnt = 0; m_idx = 0; m_sweep = 0; m_err = 0; m_rpt = 1; m_mode = 0;
        m_ports.delete();
    endtask

    task automatic model_step(input bit c, input bit s);
        int lim;
        m_sweep = 0;
        m_err   = 0;
        if (s) begin
            m_run = 0; m_cnt = 0;
        end else if (!m_run) begin
            if (c) begin
                lim = (int'(portNo) > MAX_PORTS) ? MAX_PORTS : int'(portNo);
                m_ports.delete();
                for (int p = 1; p <= lim; p++) if (io_portMask[p-1]) m_ports.push_back(p);
                m_rpt  = (io_RptNo == 0) ? 1 : int'(io_RptNo);
                m_mode = io_mode;
                if (m_ports.size() == 0) m_err = 1;
                else begin m_run = 1; m_idx = 0; m_cnt = 1; end
            end
        end else if (c) begin
            if (m_cnt < m_rpt) m_cnt++;
            else if (m_idx + 1 < m_ports.size()) begin m_idx++; m_cnt = 1; end
            else begin
                m_sweep = 1;
                if (!m_mode) begin m_idx = 0; m_cnt = 1; end
                else begin m_run = 0; m_cnt = 0; end
            end
        end
    endtask

    task automatic set_cfg(input int pn, input logic [MAX_PORTS-1:0] mask, input int rpt, input bit mode);
        portNo = PORT_W'(pn); io_portMask = mask; io_RptNo = RPT_W'(rpt); io_mode = mode;
    endtask

    // One clock: inputs are applied off-edge, model advances on the edge
    task automatic cyc(input bit c, input bit s);
        io_catch = c; io_stop = s;
        @(posedge io_clk);
        model_step(c, s);
        #1;
        io_catch = 0; io_stop = 0;
    endtask

    task automatic test_reset();
        io_rst = 1'b1;
        #12;
        n_cmp++;
        if (obs !== '0) begin
            n_bad++; $display("FAIL reset_hold: got %h want 0", obs);
        end
        @(negedge io_clk); io_rst = 1'b0; #1;
        model_reset();
        cyc(0, 0);
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_bad++; $display("FAIL reset_idle: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_basic_dwell();
        int e[9] = '{1, 1, 2, 2, 3, 3, 4, 4, 1};
        set_cfg(4, '1, 2, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(1, 0);
            n_cmp++;
            if (ctrl !== PORT_W'(e[i]) || o_sweep !== (i == 8) || obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL basic[%0d]: got ctrl=%0d sweep=%b vec=%h want ctrl=%0d sweep=%b vec=%h",
                         i, ctrl, o_sweep, obs, e[i], (i == 8), exp_vec());
            end
`ifdef MC_PORT_SCHED_ONEHOT_EN
            n_cmp++;
            if (o_onehot !== exp_onehot()) begin
                n_bad++; $display("FAIL basic_onehot[%0d]: got %h want %h", i, o_onehot, exp_onehot());
            end
`endif
        end
        cyc(0, 1);
    endtask

    task automatic test_mask_skip();
        int e[4] = '{2, 4, 6, 0};
        set_cfg(6, 32'b101010, 1, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0);
            n_cmp++;
            if (ctrl !== PORT_W'(e[i]) || o_sweep !== (i == 3) || o_busy !== (i != 3) || obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL mask_skip[%0d]: got ctrl=%0d sweep=%b busy=%b want ctrl=%0d sweep=%b busy=%b",
                         i, ctrl, o_sweep, o_busy, e[i], (i == 3), (i != 3));
            end
        end
    endtask

    task automatic test_rpt_zero();
        int e[4] = '{1, 2, 3, 0};
        set_cfg(3, '1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0);
            n_cmp++;
            if (ctrl !== PORT_W'(e[i]) || o_rptCnt !== RPT_W'(i < 3) || obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL rpt_zero[%0d]: got ctrl=%0d cnt=%0d want ctrl=%0d cnt=%0d",
                         i, ctrl, o_rptCnt, e[i], (i < 3));
            end
        end
    endtask

    task automatic test_error();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) set_cfg(4, '0, 1, 0);
            else        set_cfg(0, '1, 1, 0);
            cyc(1, 0);
            n_cmp++;
            if (o_err !== 1'b1 || ctrl !== '0 || o_busy !== 1'b0 || obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL error_pulse[%0d]: got err=%b ctrl=%0d busy=%b want err=1 ctrl=0 busy=0",
                         k, o_err, ctrl, o_busy);
            end
            cyc(0, 0);
            n_cmp++;
            if (o_err !== 1'b0 || obs !== exp_vec()) begin
                n_bad++; $display("FAIL error_clear[%0d]: got err=%b want 0", k, o_err);
            end
        end
    endtask

    task automatic test_stop_priority();
        set_cfg(4, '1, 2, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0);
        n_cmp++;
        if (ctrl !== 6'd3 || o_rptCnt !== 16'd1) begin
            n_bad++; $display("FAIL stop_setup: got ctrl=%0d cnt=%0d want ctrl=3 cnt=1", ctrl, o_rptCnt);
        end
        cyc(1, 1);
        n_cmp++;
        if (ctrl !== '0 || o_rptCnt !== '0 || o_sweep !== 1'b0 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_prio: got ctrl=%0d cnt=%0d sweep=%b busy=%b want 0 0 0 0",
                     ctrl, o_rptCnt, o_sweep, o_busy);
        end
        cyc(1, 0);
        n_cmp++;
        if (ctrl !== 6'd1 || o_rptCnt !== 16'd1 || obs !== exp_vec()) begin
            n_bad++; $display("FAIL stop_restart: got ctrl=%0d cnt=%0d want ctrl=1 cnt=1", ctrl, o_rptCnt);
        end
        cyc(0, 1);
    endtask

    task automatic test_shadowing();
        int e[4] = '{3, 4, 1, 2};
        set_cfg(4, '1, 1, 0);
        cyc(1, 0);
        cyc(1, 0);
        set_cfg(2, 32'h1, 3, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0);
            n_cmp++;
            if (ctrl !== PORT_W'(e[i]) || o_sweep !== (i == 2) || obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL shadow[%0d]: got ctrl=%0d sweep=%b want ctrl=%0d sweep=%b",
                         i, ctrl, o_sweep, e[i], (i == 2));
            end
        end
        cyc(0, 1);
        cyc(1, 0);
        n_cmp++;
        if (ctrl !== 6'd1 || o_rptCnt !== 16'd1 || obs !== exp_vec()) begin
            n_bad++; $display("FAIL shadow_newcfg: got ctrl=%0d cnt=%0d want 1 1", ctrl, o_rptCnt);
        end
        cyc(1, 0);
        n_cmp++;
        if (ctrl !== 6'd1 || o_rptCnt !== 16'd2 || obs !== exp_vec()) begin
            n_bad++; $display("FAIL shadow_newrpt: got ctrl=%0d cnt=%0d want 1 2", ctrl, o_rptCnt);
        end
        cyc(0, 1);
    endtask

    task automatic test_async_reset();
        set_cfg(8, '1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0);
        @(negedge io_clk); #1;
        io_rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== '0) begin
            n_bad++; $display("FAIL async_reset: got %h want 0", obs);
        end
        io_catch = 1'b1;
        @(posedge io_clk); #1;
        n_cmp++;
        if (obs !== '0) begin
            n_bad++; $display("FAIL reset_hold_catch: got %h want 0", obs);
        end
`ifdef MC_PORT_SCHED_ONEHOT_EN
        n_cmp++;
        if (o_onehot !== '0) begin
            n_bad++; $display("FAIL reset_onehot: got %h want 0", o_onehot);
        end
`endif
        io_catch = 1'b0;
        @(negedge io_clk); io_rst = 1'b0; #1;
        model_reset();
        cyc(1, 0);
        n_cmp++;
        if (ctrl !== 6'd1 || obs !== exp_vec()) begin
            n_bad++; $display("FAIL reset_restart: got ctrl=%0d want 1", ctrl);
        end
        cyc(0, 1);
    endtask

    task automatic test_random();
        logic [MAX_PORTS-1:0] mk;
        bit c, s;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       mk = '0;
                    1:       mk = MAX_PORTS'(1) << $urandom_range(0, MAX_PORTS - 1);
                    default: mk = $urandom;
                endcase
                set_cfg($urandom_range(0, 40), mk, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
            end
            c = ($urandom_range(0, 99) < 70);
            s = ($urandom_range(0, 99) < 3);
            cyc(c, s);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
            end
`ifdef MC_PORT_SCHED_ONEHOT_EN
            n_cmp++;
            if (o_onehot !== exp_onehot()) begin
                n_bad++; $display("FAIL random_onehot[%0d]: got %h want %h", i, o_onehot, exp_onehot());
            end
`endif
        end
        cyc(0, 1);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_dwell();
        test_mask_skip();
        test_rpt_zero();
        test_error();
        test_stop_priority();
        test_shadowing();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_port_sched.md
Name: mc_port_sched

Overview:
- Parametrised successor to the multi-channel port-rotation controller.
- Steps a 1-based port selector across up to MAX_PORTS measurement ports. It dwells on each port for a programmable number of catch events.
- Adds an enable mask that skips ports, single-sweep and continuous modes, a synchronous stop, and sweep/error status pulses.
- Sits between the trigger/catch logic and the port-switch matrix; its `ctrl` output drives the matrix select.

Parameters:
- MAX_PORTS, 32: number of physical ports. Ports are numbered 1..MAX_PORTS.
- PORT_W, 6: width of port-number signals. Must satisfy 2^PORT_W > MAX_PORTS.
- RPT_W, 16: width of the repeat counter and repeat configuration.

Ports:
- io_clk  in  1  clock
- io_rst  in  1  asynchronous, active-high reset
- io_catch  in  1  catch event; every cycle it is high counts as one event
- io_stop  in  1  synchronous abort to IDLE
- io_RptNo  in  RPT_W  catches per port; 0 is treated as 1
- portNo  in  PORT_W  highest port in use; values above MAX_PORTS are clamped to MAX_PORTS
- io_portMask  in  MAX_PORTS  bit i=1 enables port i+1
- io_mode  in  1  0 = continuous wrap, 1 = single sweep
- ctrl  out  PORT_W  selected port; 0 = none
- o_rptCnt  out  RPT_W  catches taken on the current port (1..RptNo)
- o_busy  out  1  high while in RUN
- o_sweep  out  1  one-cycle pulse when the last enabled port completes its dwell
- o_err  out  1  one-cycle pulse when a start is attempted with no enabled port

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; ctrl=0, o_rptCnt=0, o_busy=0, o_sweep=0, o_err=0. All configuration shadows are cleared.
- All outputs are registered. Response latency is 1 cycle from the catch/stop edge.
- Eligible port p: 1 <= p <= min(portNo, MAX_PORTS) and io_portMask[p-1]=1.
- FIRST = lowest eligible port. NEXT(c) = lowest eligible port greater than c; if none exists, FIRST (wrap).
- States: IDLE, RUN.
- IDLE (ctrl=0, o_busy=0):
  - On io_catch, latch io_RptNo (0 becomes 1), portNo, io_portMask and io_mode into shadows. All RUN decisions use the shadows only; config changes during RUN are ignored until the next start.
  - If at least one port is eligible: ctrl=FIRST, o_rptCnt=1, o_busy=1, go to RUN.
  - If no port is eligible: o_err=1 for 1 cycle, stay in IDLE.
- RUN, on io_catch:
  - If o_rptCnt < RptNo: o_rptCnt+1, ctrl unchanged.
  - Otherwise (dwell done):
    - If NEXT(ctrl) > ctrl: ctrl=NEXT(ctrl), o_rptCnt=1.
    - Else (wrap): o_sweep=1 for 1 cycle.
      - Continuous mode: ctrl=FIRST, o_rptCnt=1.
      - Single-sweep mode: ctrl=0, o_rptCnt=0, o_busy=0, go to IDLE.
- RUN, no io_catch: hold all state.
- Single eligible port: every dwell completion is a wrap. o_sweep pulses at each dwell end; ctrl stays on that port in continuous mode.
- io_stop in any state: next cycle ctrl=0, o_rptCnt=0, o_busy=0, state=IDLE, no o_sweep. io_stop has priority over a simultaneous io_catch; that catch is discarded.
- o_rptCnt never exceeds RptNo. RptNo = 2^RPT_W-1 is supported without overflow.
- Port search is combinational priority logic over MAX_PORTS. No multi-cycle search is permitted; every catch is serviced in 1 cycle at full rate, including back-to-back catches.
- io_rst asserted mid-sweep: immediate return to reset values. No pulses are emitted.

Optional Feature:
- Macro MC_PORT_SCHED_ONEHOT_EN.
- Defined: adds output port o_onehot [MAX_PORTS-1:0]. It is registered in the same cycle as ctrl: bit ctrl-1 is set when ctrl != 0, and the output is all zeros when ctrl = 0. Reset value is 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic dwell: MAX_PORTS=32, portNo=4, mask=all ones, RptNo=2, mode=0; 9 single-cycle catches -> ctrl sequence 1,1,2,2,3,3,4,4,1. o_sweep pulses on catch 9 only.
- Mask skip: portNo=6, mask=0b101010 (ports 2,4,6), RptNo=1, mode=1; 4 catches -> ctrl 2,4,6, then 0 with o_sweep=1 and o_busy=0.
- RptNo=0: behaves as 1; 3 catches with portNo=3 -> ctrl advances 1,2,3 on every catch.
- Error: mask=0 or portNo=0; catch -> o_err one-cycle pulse, ctrl stays 0, o_busy stays 0.
- Stop priority: in RUN at ctrl=3, o_rptCnt=1, assert io_stop and io_catch together -> next cycle ctrl=0, o_rptCnt=0, no o_sweep. The next catch restarts at FIRST.
- Shadowing and reset: change io_portMask and RptNo mid-run -> sequence unaffected until the next start. Assert io_rst mid-sweep -> all outputs 0 asynchronously. With MC_PORT_SCHED_ONEHOT_EN defined, o_onehot=1<<(ctrl-1) throughout.
